// File: rtl/spram_fifo_ctl_if.sv
// Push/pop handshake bundle between a requester and the FIFO controller.
// The requester drives the master side; the controller is the slave.
interface spram_fifo_ctl_if #(
  parameter int DW = 4
);
  logic          push;
  logic [DW-1:0] din;
  logic          push_ack;
  logic          pop;
  logic          pop_ack;
  logic [DW-1:0] dout;
  logic          dout_vld;

  modport master (
    output push,
    output din,
    output pop,
    input  push_ack,
    input  pop_ack,
    input  dout,
    input  dout_vld
  );

  modport slave (
    input  push,
    input  din,
    input  pop,
    output push_ack,
    output pop_ack,
    output dout,
    output dout_vld
  );
endinterface

// File: rtl/spram_fifo_ctl.sv
// FIFO controller in front of a single-port RAM with a registered read address.
// One RAM operation per cycle; pop wins over push, popped data arrives 2 cycles later.
module spram_fifo_ctl #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  spram_fifo_ctl_if.slave bus,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          err_ovf,
  output logic          err_unf,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_qout
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] CNT_MAX = DEPTH[AW:0];
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          rd_pend;
  logic [DW-1:0] dout_q;
  logic          vld_q;
  logic          ovf_q;
  logic          unf_q;
  logic          pop_ack;
  logic          push_ack;

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_MAX);
  assign count = cnt;

  // Reset gates both acks, which also keeps ram_wen high during reset.
  assign pop_ack  = bus.pop & ~empty & rstn;
  assign push_ack = bus.push & ~full & ~pop_ack & rstn;

  assign bus.pop_ack  = pop_ack;
  assign bus.push_ack = push_ack;
  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;

  assign ram_wen  = ~push_ack;
  assign ram_addr = push_ack ? wr_ptr : rd_ptr;
  assign ram_data = bus.din;

  assign err_ovf = ovf_q;
  assign err_unf = unf_q;

  // Pointer and occupancy bookkeeping; at most one of the acks is high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      unique case (1'b1)
        pop_ack: begin
          rd_ptr <= rd_ptr + PTR_ONE;
          cnt    <= cnt - CNT_ONE;
        end
        push_ack: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          cnt    <= cnt + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // Read return: RAM word is visible the cycle after the pop, captured then.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_pend <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      rd_pend <= pop_ack;
      vld_q   <= rd_pend;
      if (rd_pend) dout_q <= ram_qout;
    end
  end

  // Sticky error flags; a push while full but popping is not an overflow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.push & full & ~bus.pop) ovf_q <= 1'b1;
      if (bus.pop & empty) unf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spram_fifo_ctl.sv
// Randomised bench for spram_fifo_ctl with a queue-based reference model.
// Includes a behavioural 16x4 RAM with registered read address.
module tb_spram_fifo_ctl;

  logic       clk;
  logic       rstn;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       err_ovf;
  logic       err_unf;
  logic       ram_wen;
  logic [3:0] ram_addr;
  logic [3:0] ram_data;
  logic [3:0] ram_qout;

  spram_fifo_ctl_if #(.DW(4)) bus ();

  spram_fifo_ctl #(.AW(4), .DW(4)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus.slave),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .err_ovf (err_ovf),
    .err_unf (err_unf),
    .ram_wen (ram_wen),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .ram_qout(ram_qout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] mem [16];
  logic [3:0] ram_areg;

  always @(posedge clk) begin
    if (!ram_wen) mem[ram_addr] <= ram_data;
    ram_areg <= ram_addr;
  end
  assign ram_qout = mem[ram_areg];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  logic [3:0] q [$];
  int         wp, rp;
  bit         m_pend;
  logic [3:0] m_pdata;
  bit         m_vld;
  logic [3:0] m_dout;
  bit         m_ovf, m_unf;
  bit         armed = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      q.delete();
      wp = 0;
      rp = 0;
      m_pend = 0;
      m_vld = 0;
      m_dout = 4'h0;
      m_ovf = 0;
      m_unf = 0;
      armed = 1;
    end else begin
      bit pa, ua;
      int n;
      n = q.size();
      pa = bus.pop && n > 0;
      ua = bus.push && n < 16 && !pa;
      m_vld = m_pend;
      if (m_pend) m_dout = m_pdata;
      m_pend = pa;
      if (pa) begin
        m_pdata = q.pop_front();
        rp = (rp + 1) % 16;
      end
      if (ua) begin
        q.push_back(bus.din);
        wp = (wp + 1) % 16;
      end
      if (bus.push && n == 16 && !bus.pop) m_ovf = 1;
      if (bus.pop && n == 0) m_unf = 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      int n;
      bit pa, ua;
      n = q.size();
      pa = rstn && bus.pop && n > 0;
      ua = rstn && bus.push && n < 16 && !pa;
      chk("pop_ack", 32'(bus.pop_ack), 32'(pa));
      chk("push_ack", 32'(bus.push_ack), 32'(ua));
      chk("ram_wen", 32'(ram_wen), 32'(!ua));
      chk("ram_addr", 32'(ram_addr), 32'(ua ? wp : rp));
      if (ua) chk("ram_data", 32'(ram_data), 32'(bus.din));
      chk("count", 32'(count), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == 16));
      chk("dout_vld", 32'(bus.dout_vld), 32'(m_vld));
      chk("dout", 32'(bus.dout), 32'(m_dout));
      chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("err_unf", 32'(err_unf), 32'(m_unf));
    end
  end

  logic [3:0] got [$];
  always @(negedge clk) begin
    if (bus.dout_vld === 1'b1) got.push_back(bus.dout);
  end

  task automatic drv(input bit r, input bit p, input bit o,
                     input logic [3:0] d);
    rstn = r;
    bus.push = p;
    bus.pop = o;
    bus.din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_got(input string nm, input int n, input int base);
    chk({nm, "_len"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("%s_%0d", nm, i), 32'(got[i]), 32'((base + i) % 16));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    rstn = 1'b0;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.din = 4'h0;
    @(posedge clk);
    #1;
    drv(0, 0, 0, 0);
    drv(0, 0, 0, 0);
    chk("lit_rst_count", 32'(count), 32'd0);
    chk("lit_rst_empty", 32'(empty), 32'd1);
    chk("lit_rst_vld", 32'(bus.dout_vld), 32'd0);

    drv(1, 1, 0, 4'h1);
    chk("lit_count1", 32'(count), 32'd1);
    drv(1, 1, 0, 4'h2);
    drv(1, 1, 0, 4'h3);
    chk("lit_count3", 32'(count), 32'd3);

    got.delete();
    drv(1, 0, 1, 0);
    drv(1, 0, 1, 0);
    drv(1, 0, 1, 0);
    drv(1, 0, 0, 0);
    drv(1, 0, 0, 0);
    chk_got("lit_pop3", 3, 1);
    chk("lit_empty3", 32'(empty), 32'd1);
    chk("lit_unf3", 32'(err_unf), 32'd0);

    for (int i = 0; i < 16; i++) drv(1, 1, 0, 4'(i));
    chk("lit_full", 32'(full), 32'd1);
    drv(1, 1, 0, 4'h5);
    chk("lit_ovf", 32'(err_ovf), 32'd1);
    chk("lit_count16", 32'(count), 32'd16);
    got.delete();
    for (int i = 0; i < 16; i++) drv(1, 0, 1, 0);
    drv(1, 0, 0, 0);
    drv(1, 0, 0, 0);
    chk_got("lit_drain", 16, 0);

    drv(0, 0, 0, 0);
    drv(0, 0, 0, 0);
    got.delete();
    for (int k = 0; k < 10; k++) begin
      drv(1, 1, 0, 4'(2 * k));
      drv(1, 1, 0, 4'(2 * k + 1));
      drv(1, 0, 1, 0);
      drv(1, 0, 1, 0);
    end
    drv(1, 0, 0, 0);
    drv(1, 0, 0, 0);
    chk_got("lit_wrap", 20, 0);

    drv(1, 1, 0, 4'hA);
    drv(1, 1, 0, 4'hB);
    rstn = 1'b1;
    bus.push = 1'b1;
    bus.pop = 1'b1;
    bus.din = 4'hC;
    #1;
    chk("lit_both_pop", 32'(bus.pop_ack), 32'd1);
    chk("lit_both_push", 32'(bus.push_ack), 32'd0);
    @(posedge clk);
    #1;
    chk("lit_both_count", 32'(count), 32'd1);
    bus.pop = 1'b0;
    #1;
    chk("lit_held_push", 32'(bus.push_ack), 32'd1);
    @(posedge clk);
    #1;
    chk("lit_held_count", 32'(count), 32'd2);

    drv(1, 0, 1, 0);
    drv(0, 0, 0, 0);
    chk("lit_rst_vld2", 32'(bus.dout_vld), 32'd0);
    chk("lit_rst_cnt2", 32'(count), 32'd0);
    chk("lit_rst_emp2", 32'(empty), 32'd1);
    chk("lit_rst_wen", 32'(ram_wen), 32'd1);
    drv(0, 1, 0, 0);
    chk("lit_rst_wen2", 32'(ram_wen), 32'd1);

    for (int c = 0; c < 3000; c++) begin
      int ph;
      bit p, o, r;
      ph = (c / 300) % 3;
      r = ($urandom_range(0, 249) != 0);
      case (ph)
        0: begin
          p = ($urandom_range(0, 9) < 8);
          o = ($urandom_range(0, 9) < 2);
        end
        1: begin
          p = ($urandom_range(0, 9) < 2);
          o = ($urandom_range(0, 9) < 8);
        end
        default: begin
          p = $urandom_range(0, 1) == 1;
          o = $urandom_range(0, 1) == 1;
        end
      endcase
      drv(r, p, o, 4'($urandom_range(0, 15)));
    end
    drv(1, 0, 0, 0);
    drv(1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
